// File: rtl/sm_step_pkg.sv
// Shared encodings for the CPU step/rate controller.
// Mode switch codes, FSM states and a mode-to-state helper.
package sm_step_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_RUN  = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

    typedef enum logic [1:0] {
        ST_HALT  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BREAK = 2'b11
    } state_t;

    // Target state for a synchronised mode code; 11 behaves as HALT.
    function automatic state_t mode_to_state(input logic [1:0] m);
        state_t s;
        s = ST_HALT;
        if (m == MODE_RUN)  s = ST_RUN;
        if (m == MODE_STEP) s = ST_STEP;
        return s;
    endfunction

endpackage

// File: rtl/sm_debounce_filter.sv
// Two-flop synchroniser followed by a stable-count level filter.
// With STABLE <= 1 the synchronised value is passed straight through.
module sm_debounce_filter #(
    parameter int SIZE   = 1,
    parameter int STABLE = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] i_d,
    output logic [SIZE-1:0] o_q
);

    logic [SIZE-1:0] r_sync1;
    logic [SIZE-1:0] r_sync2;

    // Bring the asynchronous input into the clk domain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_d;
            r_sync2 <= r_sync1;
        end
    end

    generate
        if (STABLE <= 1) begin : g_pass
            assign o_q = r_sync2;
        end else begin : g_filt
            localparam int CW = $clog2(STABLE);

            logic [CW-1:0]   r_cnt;
            logic [SIZE-1:0] r_lvl;

            // Adopt the new value only after STABLE differing cycles in a row.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                    r_lvl <= '0;
                end else if (r_sync2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == CW'(STABLE - 1)) begin
                    r_lvl <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CW'(1);
                end
            end

            assign o_q = r_lvl;
        end
    endgenerate

endmodule

// File: rtl/sm_step_gen.sv
// CPU execution-rate controller: HALT, 2^n RUN, button STEP, PC break.
// Emits a registered one-cycle clock enable and counts retired pulses.
module sm_step_gen
    import sm_step_pkg::*;
#(
    parameter int CNT_W      = 32,
    parameter int DIV_W      = 5,
    parameter int DEB_CYCLES = 16,
    parameter int RET_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic [DIV_W-1:0] devide,
    input  logic             stepBtn,
    input  logic             bpEnable,
    input  logic [31:0]      bpAddr,
    input  logic [31:0]      pc,
    output logic             cpuEn,
    output logic [1:0]       state,
    output logic [RET_W-1:0] retCount
);

    logic [1:0]       w_mode;
    logic [DIV_W-1:0] w_devide;
    logic             w_btn;
    logic             w_step;
    logic             w_tick;
    logic             w_bp;
    int               w_d;
    logic [CNT_W-1:0] w_mask;

    state_t           r_state;
    logic             r_en;
    logic [CNT_W-1:0] r_cntr;
    logic             r_btn_d;
    logic [RET_W-1:0] r_ret;

    sm_debounce_filter #(.SIZE(2), .STABLE(1)) u_mode_sync (
        .clk (clk),
        .rst (rst),
        .i_d (mode),
        .o_q (w_mode)
    );

    sm_debounce_filter #(.SIZE(DIV_W), .STABLE(1)) u_div_sync (
        .clk (clk),
        .rst (rst),
        .i_d (devide),
        .o_q (w_devide)
    );

    sm_debounce_filter #(.SIZE(1), .STABLE(DEB_CYCLES)) u_btn_filt (
        .clk (clk),
        .rst (rst),
        .i_d (stepBtn),
        .o_q (w_btn)
    );

    // Clamp the rate exponent and build the low-bit compare mask.
    always_comb begin
        w_d    = int'(w_devide);
        w_mask = '0;
        if (w_d > CNT_W - 1) w_d = CNT_W - 1;
        for (int i = 0; i < CNT_W; i++) begin
            w_mask[i] = (i < w_d);
        end
    end

    assign w_tick = ((r_cntr & w_mask) == w_mask);
    assign w_bp   = bpEnable && (pc == bpAddr);
    assign w_step = w_btn & ~r_btn_d;

    // Delay the filtered button level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) r_btn_d <= 1'b0;
        else     r_btn_d <= w_btn;
    end

    // Mode FSM with the rate counter and the registered enable pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HALT;
            r_en    <= 1'b0;
            r_cntr  <= '0;
        end else begin
            r_en <= 1'b0;
            unique case (r_state)
                ST_HALT: begin
                    r_cntr  <= '0;
                    r_state <= mode_to_state(w_mode);
                end
                ST_RUN: begin
                    if (w_mode != MODE_RUN) begin
                        r_state <= mode_to_state(w_mode);
                        r_cntr  <= '0;
                    end else begin
                        r_cntr <= r_cntr + CNT_W'(1);
                        if (w_tick) begin
                            if (w_bp) begin
                                r_state <= ST_BREAK;
                                r_cntr  <= '0;
                            end else begin
                                r_en <= 1'b1;
                            end
                        end
                    end
                end
                ST_STEP: begin
                    r_cntr <= '0;
                    if (w_mode != MODE_STEP) begin
                        r_state <= mode_to_state(w_mode);
                    end else if (w_step) begin
                        r_en <= 1'b1;
                    end
                end
                ST_BREAK: begin
                    r_cntr <= '0;
                    if (mode_to_state(w_mode) != ST_RUN) begin
                        r_state <= mode_to_state(w_mode);
                    end else if (w_step) begin
                        r_en    <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_HALT;
                    r_cntr  <= '0;
                end
            endcase
        end
    end

    // Count every cycle the enable is high; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst)       r_ret <= '0;
        else if (r_en) r_ret <= r_ret + RET_W'(1);
    end

    assign cpuEn    = r_en;
    assign state    = r_state;
    assign retCount = r_ret;

endmodule

// File: tb/tb_sm_step_gen.sv
// Scenario bench for sm_step_gen: pulse times are queued when stimulus
// is applied and popped as cpuEn pulses appear.
module tb_sm_step_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  mode;
    logic [4:0]  devide;
    logic        stepBtn;
    logic        bpEnable;
    logic [31:0] bpAddr;
    logic [31:0] pc;
    logic        cpuEn;
    logic [1:0]  state;
    logic [3:0]  retCount;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int exp_ret  = 0;
    int t_run    = 0;
    int q[$];

    always #5 clk = ~clk;

    sm_step_gen #(
        .CNT_W      (32),
        .DIV_W      (5),
        .DEB_CYCLES (16),
        .RET_W      (4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .devide   (devide),
        .stepBtn  (stepBtn),
        .bpEnable (bpEnable),
        .bpAddr   (bpAddr),
        .pc       (pc),
        .cpuEn    (cpuEn),
        .state    (state),
        .retCount (retCount)
    );

    task automatic step_clk;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset;
        logic [1:0] es;
        rst = 1'b1; mode = 2'b01; devide = 5'd2; stepBtn = 1'b0;
        bpEnable = 1'b0; bpAddr = 32'h0; pc = 32'h0;
        repeat (3) step_clk();
        checks++;
        if (cpuEn !== 1'b0) begin
            failures++;
            $display("FAIL reset_cpuEn got=%b exp=0", cpuEn);
        end
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL reset_state got=%0d exp=0", state);
        end
        checks++;
        if (retCount !== 4'd0) begin
            failures++;
            $display("FAIL reset_ret got=%0d exp=0", retCount);
        end
        rst = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step_clk();
            es = (k == 3) ? 2'b01 : 2'b00;
            checks++;
            if (state !== es) begin
                failures++;
                $display("FAIL reset_exit_c%0d got=%0d exp=%0d", k, state, es);
            end
        end
        t_run = cyc;
    endtask

    task automatic test_run_rate;
        int e;
        logic [3:0] er;
        for (int k = 1; k <= 10; k++) q.push_back(t_run + 4 * k);
        exp_ret += 10;
        while (q.size() > 0 && cyc < t_run + 60) begin
            step_clk();
            if (cpuEn === 1'b1) begin
                e = q.pop_front();
                checks++;
                if (cyc != e) begin
                    failures++;
                    $display("FAIL run_rate_pulse got_cyc=%0d exp_cyc=%0d", cyc, e);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL run_rate_timeout got=%0d exp=0 pending", q.size());
            q.delete();
        end
        step_clk();
        er = 4'(exp_ret);
        checks++;
        if (retCount !== er) begin
            failures++;
            $display("FAIL run_rate_ret got=%0d exp=%0d", retCount, er);
        end
    endtask

    task automatic test_mode_priority;
        mode = 2'b00;
        for (int k = 1; k <= 5; k++) begin
            step_clk();
            checks++;
            if (cpuEn !== 1'b0) begin
                failures++;
                $display("FAIL prio_no_pulse c%0d got=%b exp=0", k, cpuEn);
            end
            if (k == 2) begin
                checks++;
                if (state !== 2'b01) begin
                    failures++;
                    $display("FAIL prio_still_run got=%0d exp=1", state);
                end
            end
            if (k == 3) begin
                checks++;
                if (state !== 2'b00) begin
                    failures++;
                    $display("FAIL prio_halt got=%0d exp=0", state);
                end
            end
        end
    endtask

    task automatic test_run_fast;
        int c0;
        int e;
        logic [3:0] er;
        devide = 5'd0;
        mode = 2'b01;
        c0 = cyc;
        for (int k = 4; k <= 13; k++) q.push_back(c0 + k);
        exp_ret += 10;
        while (cyc < c0 + 18) begin
            step_clk();
            if (cpuEn === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL fast_extra got_cyc=%0d exp=none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL fast_pulse got_cyc=%0d exp_cyc=%0d", cyc, e);
                    end
                end
            end
            if (cyc == c0 + 11) mode = 2'b00;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL fast_missing got=%0d exp=0 pending", q.size());
            q.delete();
        end
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL fast_halt got=%0d exp=0", state);
        end
        er = 4'(exp_ret);
        checks++;
        if (retCount !== er) begin
            failures++;
            $display("FAIL fast_ret got=%0d exp=%0d", retCount, er);
        end
    endtask

    task automatic test_bounce;
        int r;
        int e;
        logic [3:0] er;
        mode = 2'b10;
        repeat (4) step_clk();
        checks++;
        if (state !== 2'b10) begin
            failures++;
            $display("FAIL bounce_step_state got=%0d exp=2", state);
        end
        for (int seg = 0; seg < 10; seg++) begin
            stepBtn = ((seg % 2) == 0);
            for (int k = 0; k < 3; k++) begin
                step_clk();
                checks++;
                if (cpuEn !== 1'b0) begin
                    failures++;
                    $display("FAIL bounce_glitch got=%b exp=0", cpuEn);
                end
            end
        end
        stepBtn = 1'b1;
        r = cyc;
        q.push_back(r + 19);
        exp_ret += 1;
        while (cyc < r + 50) begin
            step_clk();
            if (cpuEn === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bounce_extra got_cyc=%0d exp=none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL bounce_pulse got_cyc=%0d exp_cyc=%0d", cyc, e);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL bounce_missing got=%0d exp=0 pending", q.size());
            q.delete();
        end
        stepBtn = 1'b0;
        for (int k = 0; k < 25; k++) begin
            step_clk();
            checks++;
            if (cpuEn !== 1'b0) begin
                failures++;
                $display("FAIL release_pulse got=%b exp=0", cpuEn);
            end
        end
        er = 4'(exp_ret);
        checks++;
        if (retCount !== er) begin
            failures++;
            $display("FAIL bounce_ret got=%0d exp=%0d", retCount, er);
        end
    endtask

    task automatic test_breakpoint;
        int c;
        int p;
        int e;
        logic [3:0] er;
        pc = 32'h0; bpAddr = 32'h10; bpEnable = 1'b1;
        devide = 5'd1; mode = 2'b01;
        c = cyc;
        for (int k = 0; k < 4; k++) q.push_back(c + 5 + 2 * k);
        exp_ret += 4;
        while (cyc < c + 20) begin
            step_clk();
            if (cpuEn === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra got_cyc=%0d pc=%0h", cyc, pc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL bp_pulse got_cyc=%0d exp_cyc=%0d", cyc, e);
                    end
                end
                pc = pc + 32'd4;
            end
            if (cyc == c + 13) begin
                checks++;
                if (state !== 2'b11) begin
                    failures++;
                    $display("FAIL bp_break got=%0d exp=3", state);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL bp_missing got=%0d exp=0 pending", q.size());
            q.delete();
        end
        stepBtn = 1'b1;
        p = cyc;
        for (int k = 0; k < 4; k++) q.push_back(p + 19 + 2 * k);
        exp_ret += 4;
        while (cyc < p + 35) begin
            step_clk();
            if (cpuEn === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL resume_extra got_cyc=%0d exp=none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL resume_pulse got_cyc=%0d exp_cyc=%0d", cyc, e);
                    end
                end
                pc = pc + 32'd4;
            end
            if (cyc == p + 18) begin
                checks++;
                if (state !== 2'b11) begin
                    failures++;
                    $display("FAIL bp_hold got=%0d exp=3", state);
                end
            end
            if (cyc == p + 19) begin
                checks++;
                if (state !== 2'b01) begin
                    failures++;
                    $display("FAIL bp_resume got=%0d exp=1", state);
                end
            end
            if (cyc == p + 20) stepBtn = 1'b0;
            if (cyc == p + 23) mode = 2'b00;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL resume_missing got=%0d exp=0 pending", q.size());
            q.delete();
        end
        er = 4'(exp_ret);
        checks++;
        if (retCount !== er) begin
            failures++;
            $display("FAIL bp_ret got=%0d exp=%0d", retCount, er);
        end
        bpEnable = 1'b0;
    endtask

    task automatic test_wrap_reset;
        int c;
        int e;
        logic [3:0] er;
        rst = 1'b1; mode = 2'b01; devide = 5'd0;
        repeat (2) step_clk();
        checks++;
        if (retCount !== 4'd0 || state !== 2'b00) begin
            failures++;
            $display("FAIL rerst got_ret=%0d got_st=%0d exp=0/0", retCount, state);
        end
        exp_ret = 0;
        rst = 1'b0;
        c = cyc;
        for (int k = 4; k <= 20; k++) q.push_back(c + k);
        exp_ret += 17;
        while (cyc < c + 25) begin
            step_clk();
            if (cpuEn === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL wrap_extra got_cyc=%0d exp=none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL wrap_pulse got_cyc=%0d exp_cyc=%0d", cyc, e);
                    end
                end
            end
            if (cyc == c + 18) mode = 2'b00;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL wrap_missing got=%0d exp=0 pending", q.size());
            q.delete();
        end
        er = 4'(exp_ret);
        checks++;
        if (retCount !== er) begin
            failures++;
            $display("FAIL wrap_ret got=%0d exp=%0d", retCount, er);
        end
        devide = 5'd2;
        mode = 2'b01;
        c = cyc;
        q.push_back(c + 7);
        while (cyc < c + 10) begin
            step_clk();
            if (cpuEn === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL mid_extra got_cyc=%0d exp=none", cyc);
                end else begin
                    e = q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL mid_pulse got_cyc=%0d exp_cyc=%0d", cyc, e);
                    end
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL mid_missing got=%0d exp=0 pending", q.size());
            q.delete();
        end
        rst = 1'b1;
        step_clk();
        checks++;
        if (cpuEn !== 1'b0) begin
            failures++;
            $display("FAIL mid_rst_pulse got=%b exp=0", cpuEn);
        end
        checks++;
        if (state !== 2'b00) begin
            failures++;
            $display("FAIL mid_rst_state got=%0d exp=0", state);
        end
        checks++;
        if (retCount !== 4'd0) begin
            failures++;
            $display("FAIL mid_rst_ret got=%0d exp=0", retCount);
        end
        mode = 2'b00;
        step_clk();
        rst = 1'b0;
        repeat (6) step_clk();
        checks++;
        if (state !== 2'b00 || cpuEn !== 1'b0) begin
            failures++;
            $display("FAIL post_rst got_st=%0d got_en=%b exp=0/0", state, cpuEn);
        end
    endtask

    initial begin
        test_reset();
        test_run_rate();
        test_mode_priority();
        test_run_fast();
        test_bounce();
        test_breakpoint();
        test_wrap_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sm_step_gen.md
# sm_step_gen

Parametrised CPU execution-rate controller, the successor to the fixed divider-plus-derived-clock scheme. Instead of producing a divided clock, it generates a single-cycle clock-enable (`cpuEn`) in the system clock domain. It supports three modes: halt, free run at a selectable 2^n rate, and single-step from a debounced push-button. It adds a PC breakpoint and a retired-instruction counter. It sits between board switches/buttons and the CPU's enable input in the board top level.

## Interface
- `CNT_W`, 32, width of the free-running rate counter
- `DIV_W`, 5, width of the `devide` rate select
- `DEB_CYCLES`, 16, consecutive stable cycles required by the button filter (≥2)
- `RET_W`, 32, width of the retired-pulse counter
- `clk` in 1, system clock; the only clock
- `rst` in 1, synchronous, active-high reset
- `mode` in 2, async switch input: 00 HALT, 01 RUN, 10 STEP, 11 treated as HALT
- `devide` in DIV_W, async switch input: run period = 2^devide cycles, clamped to CNT_W-1
- `stepBtn` in 1, async raw push-button, active-high
- `bpEnable` in 1, breakpoint enable (synchronous to `clk`)
- `bpAddr` in 32, breakpoint PC
- `pc` in 32, current CPU PC (synchronous to `clk`)
- `cpuEn` out 1, one-cycle CPU clock enable
- `state` out 2, FSM state: 00 HALT, 01 RUN, 10 STEP, 11 BREAK
- `retCount` out RET_W, number of `cpuEn` pulses since reset, wraps

## Operation
- `mode`, `devide` and `stepBtn` each pass through a 2-flop synchroniser.
- Synchronised `stepBtn` feeds a stability filter. The filtered level takes the new value once the synchronised value has differed from it for `DEB_CYCLES` consecutive cycles. Any reversion restarts the count.
- A step request is a one-cycle pulse on the filtered rising edge.
- Rate counter `cntr`:
  - Increments every cycle in RUN; cleared in every other state and on entry to RUN.
  - Tick = `cntr[d-1:0]` all ones, where d = min(`devide`, CNT_W-1). d = 0 ticks every cycle.
  - A change of `devide` during RUN takes effect at the next compare; no counter reset.
- FSM (registered, `cpuEn` registered):
  - HALT: `cpuEn`=0. Synced mode RUN → RUN; STEP → STEP.
  - RUN: on tick, if `bpEnable` and `pc`==`bpAddr` → BREAK with no pulse; otherwise `cpuEn`=1 next cycle. Mode ≠ RUN → HALT/STEP; mode change has priority over a tick in the same cycle.
  - STEP: each step request → `cpuEn`=1 next cycle. Breakpoint ignored. Mode change → new state.
  - BREAK: `cpuEn`=0.
    - Step request → one `cpuEn` pulse (breakpoint not rechecked), return to RUN with `cntr` cleared.
    - Mode HALT/STEP → that state.
- `retCount` increments on every cycle `cpuEn`=1; modulo 2^RET_W.

## Timing
- Reset values: `state`=HALT, `cpuEn`=0, `retCount`=0, `cntr`=0, all synchroniser and filter flops 0, filtered level 0.
- Reset mid-operation: all of the above restored on the next edge. An in-flight `cpuEn` pulse is dropped and not counted.
- Mode latency: raw `mode` change → `state` update 3 cycles later (2 sync + FSM register).
- Step latency: raw `stepBtn` rise held stable → `cpuEn` high exactly 2 + `DEB_CYCLES` + 1 cycles later.
- `cpuEn` is never high for two consecutive cycles except in RUN with d=0.
- First RUN pulse occurs 2^d cycles after `state` becomes RUN.
- A held button yields exactly one pulse. Release and re-press (each stable ≥`DEB_CYCLES`) are required for the next pulse.

## Structure
- Package `sm_step_pkg` holds the mode encodings (`MODE_HALT`, `MODE_RUN`, `MODE_STEP`) and state encodings (`ST_HALT`, `ST_RUN`, `ST_STEP`, `ST_BREAK`).
- One sub-module: `sm_debounce_filter` (params `SIZE`, `STABLE`). It contains the 2-flop synchroniser plus the stable-count filter and is instantiated for `stepBtn`.
- `mode` and `devide` use its synchroniser only (`STABLE`=1).

## Test plan
- Reset: assert `rst` with `mode`=RUN → `cpuEn`=0, `state`=00, `retCount`=0. Release → `state`=01 after 3 cycles.
- Run rate: `mode`=01, `devide`=2 → `cpuEn` pulses every 4 cycles, first 4 cycles after entering RUN. After 10 pulses, `retCount`=10. `devide`=0 → pulse every cycle.
- Bounce: `mode`=10, `DEB_CYCLES`=16, `stepBtn` toggling every 3 cycles for 30 cycles then held high 50 cycles → exactly one `cpuEn` pulse, at 19 cycles after the final rise.
- Breakpoint: `bpEnable`=1, `bpAddr`=0x10, PC model +4 per pulse from 0, `devide`=1 → pulses at pc 0, 4, 8, 0xC, then `state`=11 with no pulse. One step press → one pulse, `state`=01, run resumes.
- Mode priority: change `mode` to HALT in the same synced cycle a tick is due → no pulse, `state`=00.
- Wrap and mid-run reset: `RET_W`=4, 17 pulses → `retCount`=1. Assert `rst` one cycle before a due pulse → no pulse, all outputs at reset values.
